// File: rtl/locker_ctrl.sv
// Digital locker sequencer: collects a keypad PIN, checks it against
// a stored password, and handles lockout and password change.
module locker_ctrl #(
  parameter int          PW_LEN     = 4,
  parameter logic [15:0] DEFAULT_PW = 16'h1234,
  parameter int          MAX_FAIL   = 3,
  parameter int          OPEN_CYC   = 36_000_000,
  parameter int          LOCK_CYC   = 120_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_code,
  output logic        unlocked,
  output logic        lockout,
  output logic        err_pulse,
  output logic        ok_pulse,
  output logic [2:0]  digit_cnt,
  output logic [15:0] disp_bcd,
  output logic [1:0]  fail_cnt
);

  typedef enum logic [2:0] {
    S_LOCKED,
    S_CHECK,
    S_OPEN,
    S_SETPW,
    S_LOCKOUT
  } state_t;

  localparam logic [26:0] OPEN_LAST = 27'(OPEN_CYC - 1);
  localparam logic [26:0] LOCK_LAST = 27'(LOCK_CYC - 1);
  localparam logic [26:0] TMR_MAX   = '1;
  localparam logic [2:0]  LEN       = 3'(PW_LEN);
  localparam logic [1:0]  FAIL_MAX  = 2'(MAX_FAIL);
  localparam logic [16:0] MASK_W    =
    (17'd1 << (4 * PW_LEN)) - 17'd1;
  localparam logic [15:0] PW_MASK   = MASK_W[15:0];

  state_t      state_q, state_d;
  logic [3:0]  key_q;
  logic [26:0] tmr_q, tmr_d, tmr_inc;
  logic [15:0] buf_q, buf_d;
  logic [15:0] pw_q, pw_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  fail_q, fail_d, fail_inc;
  logic        unl_q, unl_d;
  logic        lk_q, lk_d;
  logic        err_q, err_d;
  logic        ok_q, ok_d;
  logic        ev, is_dig, is_star, is_hash;
  logic        match, entry_ok;

  assign ev      = (key_code != 4'd15) && (key_q == 4'd15);
  assign is_dig  = ev && (key_code <= 4'd9);
  assign is_star = ev && (key_code == 4'd10);
  assign is_hash = ev && (key_code == 4'd12);

  assign tmr_inc  = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 27'd1;
  assign fail_inc = fail_q + 2'd1;
  assign match    = (cnt_q == LEN) &&
                    (((buf_q ^ pw_q) & PW_MASK) == 16'd0);
  assign entry_ok = (state_q == S_LOCKED) ||
                    (state_q == S_OPEN) ||
                    (state_q == S_SETPW);

  always_comb begin
    state_d = state_q;
    tmr_d   = '0;
    buf_d   = buf_q;
    pw_d    = pw_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    err_d   = 1'b0;
    ok_d    = 1'b0;

    if (entry_ok) begin
      if (is_dig && (cnt_q < LEN)) begin
        buf_d = {buf_q[11:0], key_code};
        cnt_d = cnt_q + 3'd1;
      end
      if (is_star) begin
        buf_d = 16'hFFFF;
        cnt_d = 3'd0;
      end
    end

    unique case (state_q)
      S_LOCKED: begin
        if (is_hash) state_d = S_CHECK;
      end
      S_CHECK: begin
        buf_d = 16'hFFFF;
        cnt_d = 3'd0;
        if (match) begin
          ok_d    = 1'b1;
          fail_d  = 2'd0;
          state_d = S_OPEN;
        end else begin
          err_d = 1'b1;
          // The counter is cleared on lockout entry; lockout itself
          // is the record of the failed run.
          if (fail_inc == FAIL_MAX) begin
            fail_d  = 2'd0;
            state_d = S_LOCKOUT;
          end else begin
            fail_d  = fail_inc;
            state_d = S_LOCKED;
          end
        end
      end
      S_OPEN, S_SETPW: begin
        tmr_d = ev ? 27'd0 : tmr_inc;
        if (tmr_q == OPEN_LAST) begin
          tmr_d   = '0;
          buf_d   = 16'hFFFF;
          cnt_d   = 3'd0;
          state_d = S_LOCKED;
        end else if (is_hash) begin
          tmr_d = '0;
          buf_d = 16'hFFFF;
          cnt_d = 3'd0;
          if (state_q == S_OPEN) begin
            state_d = (cnt_q == 3'd0) ? S_SETPW : S_LOCKED;
          end else if (cnt_q == LEN) begin
            pw_d    = buf_q;
            ok_d    = 1'b1;
            state_d = S_OPEN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOCKOUT: begin
        tmr_d = tmr_inc;
        if (tmr_q == LOCK_LAST) begin
          tmr_d   = '0;
          fail_d  = 2'd0;
          state_d = S_LOCKED;
        end
      end
      default: state_d = S_LOCKED;
    endcase

    unl_d = (state_d == S_OPEN) || (state_d == S_SETPW);
    lk_d  = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOCKED;
      key_q   <= 4'd15;
      tmr_q   <= '0;
      buf_q   <= 16'hFFFF;
      pw_q    <= DEFAULT_PW;
      cnt_q   <= 3'd0;
      fail_q  <= 2'd0;
      unl_q   <= 1'b0;
      lk_q    <= 1'b0;
      err_q   <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_code;
      tmr_q   <= tmr_d;
      buf_q   <= buf_d;
      pw_q    <= pw_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      unl_q   <= unl_d;
      lk_q    <= lk_d;
      err_q   <= err_d;
      ok_q    <= ok_d;
    end
  end

  assign unlocked  = unl_q;
  assign lockout   = lk_q;
  assign err_pulse = err_q;
  assign ok_pulse  = ok_q;
  assign digit_cnt = cnt_q;
  assign disp_bcd  = buf_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_locker_ctrl.sv
// Directed bench for locker_ctrl; pulse outcomes are scored against
// an expectation queue filled when each '#' is entered.
module tb_locker_ctrl;

  localparam int OPEN_CYC = 40;
  localparam int LOCK_CYC = 100;

  typedef struct packed {
    logic       ok;
    logic       err;
    logic       unl;
    logic       lk;
    logic [1:0] fc;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key_code;
  logic        unlocked, lockout, err_pulse, ok_pulse;
  logic [2:0]  digit_cnt;
  logic [15:0] disp_bcd;
  logic [1:0]  fail_cnt;

  int   checks = 0;
  int   errors = 0;
  int   lk_cycles = 0;
  res_t sb[$];
  res_t obsq[$];

  locker_ctrl #(
    .PW_LEN(4),
    .DEFAULT_PW(16'h1234),
    .MAX_FAIL(3),
    .OPEN_CYC(OPEN_CYC),
    .LOCK_CYC(LOCK_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_code(key_code),
    .unlocked(unlocked),
    .lockout(lockout),
    .err_pulse(err_pulse),
    .ok_pulse(ok_pulse),
    .digit_cnt(digit_cnt),
    .disp_bcd(disp_bcd),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ok_pulse || err_pulse)
      obsq.push_back('{ok_pulse, err_pulse, unlocked,
                       lockout, fail_cnt});
    if (lockout) lk_cycles++;
  end

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(logic [3:0] k);
    key_code = k;
    repeat (5) @(negedge clk);
    key_code = 4'd15;
    repeat (5) @(negedge clk);
  endtask

  task automatic enter(logic [15:0] pin);
    logic [15:0] p;
    p = pin;
    for (int i = 3; i >= 0; i--) press(p[4*i +: 4]);
  endtask

  task automatic expect_res(logic ok, logic err, logic unl,
                            logic lk, logic [1:0] fc);
    sb.push_back('{ok, err, unl, lk, fc});
  endtask

  task automatic wait_result(string tag);
    int   n;
    res_t o, e;
    n = 0;
    while (obsq.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (obsq.size() > 0) else begin
      errors++;
      $error("FAIL %s: got no pulse expected one", tag);
    end
    if (obsq.size() > 0 && sb.size() > 0) begin
      o = obsq.pop_front();
      e = sb.pop_front();
      chk(tag, 32'(o), 32'(e));
    end
  endtask

  task automatic wait_unlock_fall(string tag);
    int n;
    n = 0;
    while (unlocked && n < 4 * OPEN_CYC) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(unlocked), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    key_code = 4'd15;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_unlocked", 32'(unlocked), 32'd0);
    chk("rst_lockout", 32'(lockout), 32'd0);
    chk("rst_cnt", 32'(digit_cnt), 32'd0);
    chk("rst_disp", 32'(disp_bcd), 32'hFFFF);
    chk("rst_fail", 32'(fail_cnt), 32'd0);
    chk("rst_pulses", 32'({ok_pulse, err_pulse}), 32'd0);

    // correct PIN with exact latency on '#'
    enter(16'h1234);
    chk("t1_cnt", 32'(digit_cnt), 32'd4);
    chk("t1_disp", 32'(disp_bcd), 32'h1234);
    expect_res(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    key_code = 4'd12;
    @(negedge clk);
    chk("t1_lat1", 32'(unlocked), 32'd0);
    @(negedge clk);
    chk("t1_lat2", 32'({unlocked, ok_pulse}), 32'h3);
    repeat (3) @(negedge clk);
    key_code = 4'd15;
    repeat (5) @(negedge clk);
    wait_result("t1_ok");
    chk("t1_clr", 32'(disp_bcd), 32'hFFFF);

    // open timeout measured from a held '*'
    key_code = 4'd10;
    @(negedge clk);
    repeat (OPEN_CYC - 1) @(negedge clk);
    chk("t5_before", 32'(unlocked), 32'd1);
    @(negedge clk);
    chk("t5_fall", 32'(unlocked), 32'd0);
    key_code = 4'd15;
    repeat (5) @(negedge clk);

    // three wrong PINs into lockout
    expect_res(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    enter(16'h1235);
    press(4'd12);
    wait_result("t2_err1");
    expect_res(1'b0, 1'b1, 1'b0, 1'b0, 2'd2);
    enter(16'h1235);
    press(4'd12);
    wait_result("t2_err2");
    expect_res(1'b0, 1'b1, 1'b0, 1'b1, 2'd0);
    enter(16'h1235);
    press(4'd12);
    wait_result("t2_err3");
    press(4'd1);
    press(4'd12);
    chk("t2_lk_cnt", 32'(digit_cnt), 32'd0);
    chk("t2_lk_on", 32'(lockout), 32'd1);
    for (int n = 0; n < 3 * LOCK_CYC && lockout; n++)
      @(negedge clk);
    chk("t2_lk_off", 32'(lockout), 32'd0);
    chk("t2_lk_len", 32'(lk_cycles), 32'(LOCK_CYC));
    chk("t2_fail0", 32'(fail_cnt), 32'd0);

    // buffer saturation and clear
    enter(16'h1234);
    press(4'd5);
    press(4'd6);
    chk("t3_cnt", 32'(digit_cnt), 32'd4);
    chk("t3_disp", 32'(disp_bcd), 32'h1234);
    press(4'd10);
    chk("t3_clr_cnt", 32'(digit_cnt), 32'd0);
    chk("t3_clr_disp", 32'(disp_bcd), 32'hFFFF);

    // password change flow
    expect_res(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    enter(16'h1234);
    press(4'd12);
    wait_result("t4_open");
    press(4'd12);
    chk("t4_setpw", 32'(unlocked), 32'd1);
    expect_res(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);
    press(4'd9);
    press(4'd8);
    press(4'd12);
    wait_result("t4_short");
    expect_res(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    enter(16'h9876);
    press(4'd12);
    wait_result("t4_chg");
    wait_unlock_fall("t4_tmo");
    expect_res(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    enter(16'h9876);
    press(4'd12);
    wait_result("t4_new");
    press(4'd1);
    press(4'd12);
    chk("t4_relock", 32'(unlocked), 32'd0);
    expect_res(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
    enter(16'h1234);
    press(4'd12);
    wait_result("t4_old");

    // reset during password change restores default
    expect_res(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    enter(16'h9876);
    press(4'd12);
    wait_result("t6_open");
    press(4'd12);
    press(4'd1);
    press(4'd2);
    chk("t6_cnt2", 32'(digit_cnt), 32'd2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_unl", 32'(unlocked), 32'd0);
    chk("t6_disp", 32'(disp_bcd), 32'hFFFF);
    chk("t6_cnt", 32'(digit_cnt), 32'd0);
    expect_res(1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
    enter(16'h1234);
    press(4'd12);
    wait_result("t6_dflt");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("obs_empty", 32'(obsq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
